// File: rtl/fsm_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_engine_pkg
//  Description : Shared types and helpers for the table-driven FSM engine.
//                Defines the decision-path enum and the arc slice helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsm_engine_pkg;

    // Which branch of the next-state priority chain produced next_state
    typedef enum logic [2:0] {
        PATH_FORCE   = 3'd0,
        PATH_HOLD    = 3'd1,
        PATH_ARC     = 3'd2,
        PATH_TIMEOUT = 3'd3,
        PATH_STAY    = 3'd4,
        PATH_RECOVER = 3'd5
    } path_e;

    // LSB position of arc 'idx' inside a packed arc table of 'width'-bit fields
    function automatic int arc_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_engine_logic.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_engine_logic
//  Description : Combinational decision core. Evaluates the arc table against
//                the current state and resolves force/hold/arc/timeout/stay/
//                recovery priority into next_state, winner one-hot and path.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_engine_logic
    import fsm_engine_pkg::*;
#(
    parameter int STATE_W = 2,
    parameter int N_ARCS  = 4,
    parameter int TIMER_W = 8
) (
    input  logic [STATE_W-1:0]        state,
    input  logic [TIMER_W-1:0]        dwell,
    input  logic [STATE_W-1:0]        default_state,
    input  logic [N_ARCS*STATE_W-1:0] arc_src,
    input  logic [N_ARCS*STATE_W-1:0] arc_dst,
    input  logic [N_ARCS-1:0]         arc_en,
    input  logic [N_ARCS-1:0]         arc_cond,
    input  logic                      hold,
    input  logic                      force_valid,
    input  logic [STATE_W-1:0]        force_state,
    input  logic [TIMER_W-1:0]        timeout_limit,
    input  logic [STATE_W-1:0]        timeout_dst,
    output logic [STATE_W-1:0]        next_state,
    output logic [N_ARCS-1:0]         win_onehot,
    output path_e                     path
);

    logic [N_ARCS-1:0]  w_hit;
    logic [N_ARCS-1:0]  w_fire;
    logic [N_ARCS-1:0]  w_win;
    logic [STATE_W-1:0] w_dst [N_ARCS];
    logic [STATE_W-1:0] w_win_dst;
    logic               w_timeout;

    for (genvar gi = 0; gi < N_ARCS; gi++) begin : g_arc
        assign w_hit[gi]  = arc_en[gi] &&
                            (arc_src[arc_lsb(gi, STATE_W) +: STATE_W] == state);
        assign w_fire[gi] = w_hit[gi] && arc_cond[gi];
        assign w_dst[gi]  = arc_dst[arc_lsb(gi, STATE_W) +: STATE_W];
    end

    // Isolate the lowest set bit: arc 0 has the highest priority
    assign w_win = w_fire & (-w_fire);

    // The winner is one-hot, so OR-ing the gated destinations selects it
    always_comb begin
        w_win_dst = '0;
        for (int i = 0; i < N_ARCS; i++) begin
            if (w_win[i]) begin
                w_win_dst = w_win_dst | w_dst[i];
            end
        end
    end

    // Timeout only applies while the state is a legal (sourced) state
    assign w_timeout = (timeout_limit != '0) && (dwell >= timeout_limit) && (|w_hit);

    // Priority chain: force > hold > arc > timeout > stay > recover
    always_comb begin
        next_state = state;
        win_onehot = '0;
        path       = PATH_STAY;
        if (force_valid) begin
            next_state = force_state;
            path       = PATH_FORCE;
        end else if (hold) begin
            next_state = state;
            path       = PATH_HOLD;
        end else if (|w_fire) begin
            next_state = w_win_dst;
            win_onehot = w_win;
            path       = PATH_ARC;
        end else if (w_timeout) begin
            next_state = timeout_dst;
            path       = PATH_TIMEOUT;
        end else if (|w_hit) begin
            next_state = state;
            path       = PATH_STAY;
        end else begin
            next_state = default_state;
            path       = PATH_RECOVER;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_engine
//  Description : Table-driven Moore state-machine engine. Holds the state,
//                previous-state and dwell registers and generates the
//                one-cycle diagnostic pulses around the decision core.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_engine
    import fsm_engine_pkg::*;
#(
    parameter int STATE_W = 2,
    parameter int N_ARCS  = 4,
    parameter int TIMER_W = 8
) (
    input  logic                      clock_port,
    input  logic                      reset_port,
    input  logic [STATE_W-1:0]        reset_value,
    input  logic [STATE_W-1:0]        default_state,
    input  logic [N_ARCS*STATE_W-1:0] arc_src,
    input  logic [N_ARCS*STATE_W-1:0] arc_dst,
    input  logic [N_ARCS-1:0]         arc_en,
    input  logic [N_ARCS-1:0]         arc_cond,
    input  logic                      hold,
    input  logic                      force_valid,
    input  logic [STATE_W-1:0]        force_state,
    input  logic [TIMER_W-1:0]        timeout_limit,
    input  logic [STATE_W-1:0]        timeout_dst,
    output logic [STATE_W-1:0]        state,
    output logic [STATE_W-1:0]        next_state,
    output logic [STATE_W-1:0]        prev_state,
    output logic                      state_changed,
    output logic [N_ARCS-1:0]         arc_taken,
    output logic [TIMER_W-1:0]        dwell,
    output logic                      recovered,
    output logic                      timed_out
);

    localparam logic [TIMER_W-1:0] c_dwell_one = TIMER_W'(1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_prev_state;
    logic               r_state_changed;
    logic [N_ARCS-1:0]  r_arc_taken;
    logic [TIMER_W-1:0] r_dwell;
    logic               r_recovered;
    logic               r_timed_out;

    logic [STATE_W-1:0] w_next_state;
    logic [N_ARCS-1:0]  w_win_onehot;
    path_e              w_path;
    logic [TIMER_W-1:0] w_dwell_next;

    fsm_engine_logic #(
        .STATE_W (STATE_W),
        .N_ARCS  (N_ARCS),
        .TIMER_W (TIMER_W)
    ) u_logic (
        .state         (r_state),
        .dwell         (r_dwell),
        .default_state (default_state),
        .arc_src       (arc_src),
        .arc_dst       (arc_dst),
        .arc_en        (arc_en),
        .arc_cond      (arc_cond),
        .hold          (hold),
        .force_valid   (force_valid),
        .force_state   (force_state),
        .timeout_limit (timeout_limit),
        .timeout_dst   (timeout_dst),
        .next_state    (w_next_state),
        .win_onehot    (w_win_onehot),
        .path          (w_path)
    );

    // Dwell restarts on any taken transition (self-loops included), freezes on hold
    always_comb begin
        w_dwell_next = r_dwell;
        case (w_path)
            PATH_FORCE, PATH_ARC, PATH_TIMEOUT, PATH_RECOVER: w_dwell_next = '0;
            PATH_HOLD:                                        w_dwell_next = r_dwell;
            PATH_STAY: w_dwell_next = (r_dwell == '1) ? r_dwell : r_dwell + c_dwell_one;
            default:                                          w_dwell_next = r_dwell;
        endcase
    end

    // State, history, dwell and single-cycle event pulses
    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            r_state         <= reset_value;
            r_prev_state    <= reset_value;
            r_dwell         <= '0;
            r_state_changed <= 1'b0;
            r_arc_taken     <= '0;
            r_recovered     <= 1'b0;
            r_timed_out     <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            if (w_next_state != r_state) begin
                r_prev_state <= r_state;
            end
            r_state_changed <= (w_next_state != r_state);
            r_arc_taken     <= w_win_onehot;
            r_dwell         <= w_dwell_next;
            r_recovered     <= (w_path == PATH_RECOVER);
            r_timed_out     <= (w_path == PATH_TIMEOUT);
        end
    end

    assign state         = r_state;
    assign next_state    = w_next_state;
    assign prev_state    = r_prev_state;
    assign state_changed = r_state_changed;
    assign arc_taken     = r_arc_taken;
    assign dwell         = r_dwell;
    assign recovered     = r_recovered;
    assign timed_out     = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_fsm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_engine
//  Description : Self-checking bench for fsm_engine (STATE_W=2, N_ARCS=4,
//                TIMER_W=3). A behavioural model pushes expected register
//                values into a scoreboard queue each cycle; they are popped
//                and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_engine;

    localparam int c_sw = 2;
    localparam int c_na = 4;
    localparam int c_tw = 3;
    localparam int c_dwell_max = (1 << c_tw) - 1;

    localparam int c_p_force   = 0;
    localparam int c_p_hold    = 1;
    localparam int c_p_arc     = 2;
    localparam int c_p_timeout = 3;
    localparam int c_p_stay    = 4;
    localparam int c_p_recover = 5;

    logic                   clk;
    logic                   reset_port;
    logic [c_sw-1:0]        reset_value;
    logic [c_sw-1:0]        default_state;
    logic [c_na*c_sw-1:0]   arc_src;
    logic [c_na*c_sw-1:0]   arc_dst;
    logic [c_na-1:0]        arc_en;
    logic [c_na-1:0]        arc_cond;
    logic                   hold;
    logic                   force_valid;
    logic [c_sw-1:0]        force_state;
    logic [c_tw-1:0]        timeout_limit;
    logic [c_sw-1:0]        timeout_dst;
    logic [c_sw-1:0]        state;
    logic [c_sw-1:0]        next_state;
    logic [c_sw-1:0]        prev_state;
    logic                   state_changed;
    logic [c_na-1:0]        arc_taken;
    logic [c_tw-1:0]        dwell;
    logic                   recovered;
    logic                   timed_out;

    typedef struct packed {
        logic [c_sw-1:0] st;
        logic [c_sw-1:0] prev;
        logic            chg;
        logic [c_na-1:0] arc;
        logic [c_tw-1:0] dw;
        logic            rec;
        logic            to;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [c_sw-1:0] m_state;
    logic [c_sw-1:0] m_prev;
    int              m_dwell;

    fsm_engine #(
        .STATE_W (c_sw),
        .N_ARCS  (c_na),
        .TIMER_W (c_tw)
    ) dut (
        .clock_port    (clk),
        .reset_port    (reset_port),
        .reset_value   (reset_value),
        .default_state (default_state),
        .arc_src       (arc_src),
        .arc_dst       (arc_dst),
        .arc_en        (arc_en),
        .arc_cond      (arc_cond),
        .hold          (hold),
        .force_valid   (force_valid),
        .force_state   (force_state),
        .timeout_limit (timeout_limit),
        .timeout_dst   (timeout_dst),
        .state         (state),
        .next_state    (next_state),
        .prev_state    (prev_state),
        .state_changed (state_changed),
        .arc_taken     (arc_taken),
        .dwell         (dwell),
        .recovered     (recovered),
        .timed_out     (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decision straight from the priority list
    task automatic model_decide(output logic [c_sw-1:0] nxt, output int path,
                                output logic [c_na-1:0] win);
        bit hit_any = 1'b0;
        int winner  = -1;
        for (int i = 0; i < c_na; i++) begin
            if (arc_en[i] && arc_src[i*c_sw +: c_sw] == m_state) begin
                hit_any = 1'b1;
                if (arc_cond[i] && winner < 0) winner = i;
            end
        end
        win = '0;
        if (force_valid) begin
            nxt = force_state;  path = c_p_force;
        end else if (hold) begin
            nxt = m_state;      path = c_p_hold;
        end else if (winner >= 0) begin
            nxt = arc_dst[winner*c_sw +: c_sw];
            win[winner] = 1'b1; path = c_p_arc;
        end else if (timeout_limit != 0 && m_dwell >= int'(timeout_limit) && hit_any) begin
            nxt = timeout_dst;  path = c_p_timeout;
        end else if (hit_any) begin
            nxt = m_state;      path = c_p_stay;
        end else begin
            nxt = default_state; path = c_p_recover;
        end
    endtask

    // One clock: predict, push, clock, pop, compare
    task automatic cyc();
        exp_t            e;
        exp_t            got;
        logic [c_sw-1:0] nxt;
        int              path;
        logic [c_na-1:0] win;
        int              dw;
        #1;
        e = '0;
        if (reset_port) begin
            e.st   = reset_value;
            e.prev = reset_value;
        end else begin
            model_decide(nxt, path, win);
            check("next_state", 32'(next_state), 32'(nxt));
            e.st   = nxt;
            e.prev = (nxt != m_state) ? m_state : m_prev;
            e.chg  = (nxt != m_state);
            e.arc  = win;
            e.rec  = (path == c_p_recover);
            e.to   = (path == c_p_timeout);
            if (path == c_p_hold)      dw = m_dwell;
            else if (path == c_p_stay) dw = (m_dwell == c_dwell_max) ? m_dwell : m_dwell + 1;
            else                       dw = 0;
            e.dw   = c_tw'(dw);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            got = sb.pop_front();
            check("sb_state",   32'(state),         32'(got.st));
            check("sb_prev",    32'(prev_state),    32'(got.prev));
            check("sb_changed", 32'(state_changed), 32'(got.chg));
            check("sb_arc",     32'(arc_taken),     32'(got.arc));
            check("sb_dwell",   32'(dwell),         32'(got.dw));
            check("sb_recov",   32'(recovered),     32'(got.rec));
            check("sb_timeout", 32'(timed_out),     32'(got.to));
            m_state = got.st;
            m_prev  = got.prev;
            m_dwell = int'(got.dw);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        // Table: arc0 0->1, arc1 0->3, arc2 1->2, arc3 2->0 (listed arc3..arc0)
        reset_port    = 1'b1;
        reset_value   = 2'd1;
        default_state = 2'd0;
        arc_src       = {2'd2, 2'd1, 2'd0, 2'd0};
        arc_dst       = {2'd0, 2'd2, 2'd3, 2'd1};
        arc_en        = 4'b1111;
        arc_cond      = 4'b0000;
        hold          = 1'b0;
        force_valid   = 1'b0;
        force_state   = 2'd0;
        timeout_limit = '0;
        timeout_dst   = 2'd1;
        m_state       = '0;
        m_prev        = '0;
        m_dwell       = 0;

        // Reset for 3 cycles
        repeat (3) cyc();
        check("rst_state",  32'(state), 32'd1);
        check("rst_prev",   32'(prev_state), 32'd1);
        check("rst_dwell",  32'(dwell), 32'd0);
        check("rst_pulses", 32'({state_changed, arc_taken, recovered, timed_out}), 32'd0);

        // Dwell counts 1,2,3 in state 1
        reset_port = 1'b0;
        cyc(); check("dwell_1", 32'(dwell), 32'd1);
        cyc(); check("dwell_2", 32'(dwell), 32'd2);
        cyc(); check("dwell_3", 32'(dwell), 32'd3);

        // Priority: force to 0, then arcs 0 and 1 both fire
        force_valid = 1'b1; force_state = 2'd0;
        cyc(); check("force0_state", 32'(state), 32'd0);
        force_valid = 1'b0; arc_cond = 4'b0011;
        cyc();
        check("prio_state",   32'(state), 32'd1);
        check("prio_arc",     32'(arc_taken), 32'b0001);
        check("prio_changed", 32'(state_changed), 32'd1);
        check("prio_prev",    32'(prev_state), 32'd0);

        // Timeout: enter state 2, limit 4 -> leaves after 5 cycles
        arc_cond = 4'b0100;
        cyc(); check("to_enter", 32'(state), 32'd2);
        arc_cond = 4'b0000; timeout_limit = 3'd4;
        repeat (4) cyc();
        check("to_pre_state", 32'(state), 32'd2);
        check("to_pre_dwell", 32'(dwell), 32'd4);
        check("to_pre_pulse", 32'(timed_out), 32'd0);
        cyc();
        check("to_state", 32'(state), 32'd1);
        check("to_pulse", 32'(timed_out), 32'd1);
        check("to_dwell", 32'(dwell), 32'd0);
        timeout_limit = '0;
        cyc(); check("to_pulse_end", 32'(timed_out), 32'd0);

        // Recovery from an unsourced state
        force_valid = 1'b1; force_state = 2'd3;
        cyc(); check("rec_force3", 32'(state), 32'd3);
        force_valid = 1'b0;
        cyc();
        check("rec_state", 32'(state), 32'd0);
        check("rec_pulse", 32'(recovered), 32'd1);
        cyc(); check("rec_pulse_end", 32'(recovered), 32'd0);

        // Force beats hold; hold freezes state and dwell
        hold = 1'b1; force_valid = 1'b1; force_state = 2'd2;
        cyc(); check("hf_state", 32'(state), 32'd2);
        force_valid = 1'b0; hold = 1'b0;
        repeat (2) cyc();
        hold = 1'b1;
        repeat (10) cyc();
        check("hold_state", 32'(state), 32'd2);
        check("hold_dwell", 32'(dwell), 32'd2);

        // Saturation at 7
        hold = 1'b0;
        repeat (12) cyc();
        check("sat_dwell", 32'(dwell), 32'd7);

        // Self-loop arc 2->2 clears dwell, no state change
        arc_dst[7:6] = 2'd2; arc_cond = 4'b1000;
        cyc();
        check("self_dwell", 32'(dwell), 32'd0);
        check("self_arc",   32'(arc_taken), 32'b1000);
        check("self_chg",   32'(state_changed), 32'd0);
        arc_cond = 4'b0000;
        cyc(); check("self_arc_end", 32'(arc_taken), 32'd0);

        // Reset overrides force mid-operation
        force_valid = 1'b1; force_state = 2'd3; reset_port = 1'b1;
        cyc(); check("mrst_state", 32'(state), 32'd1);
        reset_port = 1'b0; force_valid = 1'b0;
        cyc();
        check("mrst_after_state", 32'(state), 32'd1);
        check("mrst_after_dwell", 32'(dwell), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_engine.md
# fsm_engine

Parametrised, table-driven Moore state-machine engine, the next generation of the generated FSM/FSMLogic pair. It supports any state width, any number of transition arcs with strict priority, a force/hold control path, a dwell counter and a timeout arc, and it recovers from undefined states. It sits beside user logic exactly where the generated FSM does today: the arc table is driven from static or quasi-static signals, and the block reports the current state, next state and arc diagnostics.

## Interface

Parameters:
- STATE_W, default 2: state encoding width.
- N_ARCS, default 4: number of transition arcs; arc 0 has the highest priority.
- TIMER_W, default 8: width of the dwell counter and the timeout limit.

Ports:
- clock_port  in  1  the single clock.
- reset_port  in  1  reset; synchronous, active-high.
- reset_value  in  STATE_W  state loaded while reset is asserted.
- default_state  in  STATE_W  recovery target when the current state is the source of no enabled arc.
- arc_src  in  N_ARCS*STATE_W  source state of each arc; arc i occupies bits [i*STATE_W +: STATE_W].
- arc_dst  in  N_ARCS*STATE_W  destination state of each arc.
- arc_en  in  N_ARCS  arc exists / is enabled.
- arc_cond  in  N_ARCS  transition condition of each arc.
- hold  in  1  freeze the state and the dwell counter.
- force_valid  in  1  jump request.
- force_state  in  STATE_W  jump target.
- timeout_limit  in  TIMER_W  dwell limit; 0 disables the timeout.
- timeout_dst  in  STATE_W  timeout target.
- state  out  STATE_W  registered current state.
- next_state  out  STATE_W  combinational next state.
- prev_state  out  STATE_W  registered state before the last change.
- state_changed  out  1  registered one-cycle pulse.
- arc_taken  out  N_ARCS  registered one-hot arc used by the last update.
- dwell  out  TIMER_W  cycles spent in the current state.
- recovered  out  1  registered pulse: the default_state path was used.
- timed_out  out  1  registered pulse: the timeout path was used.

## Operation

- A source hit means some arc i has arc_en[i]=1 and arc_src[i]==state.
- A fire means a source hit that also has arc_cond[i]=1. The winner is the lowest-index firing arc.
- next_state priority, highest first:
  1. force_valid: force_state.
  2. hold: state.
  3. A firing arc exists: arc_dst of the winner.
  4. timeout_limit!=0, dwell>=timeout_limit and a source hit: timeout_dst.
  5. A source hit exists: state (stay).
  6. Otherwise: default_state, and recovered pulses.
- Each clock, state loads next_state.
- Dwell counter:
  - Cleared when a force, arc or timeout is taken. This includes a self-loop arc whose destination equals its source.
  - Frozen under hold.
  - Otherwise increments, saturating at all-ones.
  - Also cleared on the recovery path.
- prev_state loads the old state only when the new value differs; state_changed is then 1.
- arc_taken is the one-hot winner, and is 0 for force, hold, timeout, stay and recovery.
- Reset, synchronous, overrides everything including force_valid:
  - state=reset_value, prev_state=reset_value.
  - dwell=0.
  - state_changed, arc_taken, recovered and timed_out all 0.
- Reset asserted mid-operation aborts the cycle's update. The first update after release is evaluated from reset_value with dwell=0.

## Timing

- next_state is combinational from state, the arc table and the controls, with zero latency.
- state, dwell and all pulses are valid one cycle after the decision edge.
- Pulses last exactly one cycle per event and never stretch across hold.
- When the timeout is enabled it first fires on the cycle where dwell==timeout_limit, so the state has been occupied for timeout_limit+1 cycles.
- If an arc fires on that same cycle, the arc wins and timed_out stays 0.
- Arc table changes take effect combinationally. The table must not be sampled mid-cycle for anything else.

## Structure

- Package fsm_engine_pkg holds:
  - an arc-index helper function (slice extraction);
  - the decision-path enum: PATH_FORCE, PATH_HOLD, PATH_ARC, PATH_TIMEOUT, PATH_STAY, PATH_RECOVER.
- Sub-module fsm_engine_logic (combinational) takes state, dwell, the table and the controls, and produces next_state, the winning index one-hot and the path enum.
- The top level contains the registers, the dwell counter and the pulse generation.

## Test plan

- Reset, then dwell: STATE_W=2 and reset_value=1. Hold reset_port for 3 cycles and release → state=1, dwell=0, all pulses 0. Dwell then counts 1, 2, 3.
- Priority: arcs 0 (0→1) and 1 (0→3) both enabled with cond=1, in state 0 → next_state=1, arc_taken=0001, state_changed pulses, prev_state=0.
- Timeout: timeout_limit=4, state 2, no arcs firing → state goes to timeout_dst after 5 cycles in state 2, timed_out pulses once, dwell=0.
- Recovery: force state 3 with no arcs sourced at 3 and default_state=0 → the next cycle gives state=0 and recovered=1.
- Hold versus force: hold=1 and force_valid=1 with force_state=2 → state=2. Hold alone for 10 cycles → state and dwell frozen.
- Saturation and self-loop: TIMER_W=3 and stay 12 cycles → dwell saturates at 7. A self-loop arc 2→2 clears dwell and pulses arc_taken with no state_changed.
